// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch requester and the load/store requester. One transaction
// is in flight at a time: IDLE (accept) -> ISSUE (mem_en) -> [WAIT] -> RESP.
// Optional macro MEM_ARB_RR_EN: round-robin arbitration instead of the
// default fixed priority (data > fetch).
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic                  d_req_we,
  input  logic [3:0]            d_req_wstrb,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Counter is 2 bits wide since MEM_LATENCY-1 is at most 3.
  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

  state_t                state, state_nxt;
  logic [1:0]            cnt;
  logic                  pick_d;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  // On a tie the requester that did not win last time gets the port.
  always_comb pick_d = d_req_valid && (!if_req_valid || !last_grant);

  // Remember the most recent winner, updated only when a request is taken.
  always_ff @(posedge clk) begin
    if (rst)         last_grant <= 1'b0;
    else if (accept) last_grant <= pick_d;
  end
`else
  // Fixed priority: a pending data request always beats fetch.
  always_comb pick_d = d_req_valid;
`endif

  // Readies exist only in IDLE and only for the winner.
  always_comb begin
    d_req_ready  = (state == IDLE) && pick_d;
    if_req_ready = (state == IDLE) && if_req_valid && !pick_d;
    accept       = d_req_ready || if_req_ready;
    sel_addr     = pick_d ? d_req_addr : if_req_addr;
  end

  // Response side is decoded from state; read data passes straight through.
  always_comb begin
    busy         = (state != IDLE);
    if_rsp_valid = (state == RESP) && !grant_id;
    d_rsp_valid  = (state == RESP) && grant_id;
    if_rsp_data  = mem_rdata;
    d_rsp_data   = mem_rdata;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: sequence one access through the memory latency.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = (MEM_LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 2'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port registers, owner and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant_id  <= 1'b0;
      cnt       <= 2'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          // Low address bits are dropped; fetch never writes.
          mem_en    <= 1'b1;
          mem_we    <= (pick_d && d_req_we) ? d_req_wstrb : 4'b0000;
          mem_addr  <= sel_addr & ~ADDR_WIDTH'(3);
          mem_wdata <= d_req_wdata;
          grant_id  <= pick_d;
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 4'b0000;
          cnt    <= CNT_INIT;
        end
        WAIT:    cnt <= cnt - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1 and one
// at MEM_LATENCY=3 share the same stimulus; each test checks one instance.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, d_req_valid, d_req_we;
  logic [31:0] if_req_addr, d_req_addr, d_req_wdata, mem_rdata;
  logic [3:0]  d_req_wstrb;

  logic        if_rdy1, if_rsp1, d_rdy1, d_rsp1, men1, busy1, gid1;
  logic [31:0] if_dat1, d_dat1, maddr1, mwd1;
  logic [3:0]  mwe1;
  logic        if_rdy3, if_rsp3, d_rdy3, d_rsp3, men3, busy3, gid3;
  logic [31:0] if_dat3, d_dat3, maddr3, mwd3;
  logic [3:0]  mwe3;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_rdy1), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp1), .if_rsp_data(if_dat1),
    .d_req_valid(d_req_valid), .d_req_ready(d_rdy1), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp1), .d_rsp_data(d_dat1),
    .mem_en(men1), .mem_we(mwe1), .mem_addr(maddr1), .mem_wdata(mwd1),
    .mem_rdata(mem_rdata), .busy(busy1), .grant_id(gid1)
  );

  mem_port_arbiter #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_rdy3), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp3), .if_rsp_data(if_dat3),
    .d_req_valid(d_req_valid), .d_req_ready(d_rdy3), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp3), .d_rsp_data(d_dat3),
    .mem_en(men3), .mem_we(mwe3), .mem_addr(maddr3), .mem_wdata(mwd3),
    .mem_rdata(mem_rdata), .busy(busy3), .grant_id(gid3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
    if_req_addr = '0; d_req_addr = '0; d_req_wstrb = '0; d_req_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  int   nacc;
  logic exp_w, last_w;
  logic seen_rsp;

  initial begin
    idle_inputs();
    mem_rdata = 32'h0;
    do_reset();
    #1;
    chk("rst_busy", {31'b0, busy1}, 32'd0);
    chk("rst_men", {31'b0, men1}, 32'd0);
    chk("rst_maddr", maddr1, 32'd0);
    chk("rst_gid", {31'b0, gid1}, 32'd0);
    chk("rst_rsp", {30'b0, if_rsp1, d_rsp1}, 32'd0);

    // Fetch, latency 1
    step();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    #1 chk("f_ready_T", {31'b0, if_rdy1}, 32'd1);
    step(); idle_inputs();
    #1;
    chk("f_men_T1", {31'b0, men1}, 32'd1);
    chk("f_maddr_T1", maddr1, 32'h10);
    chk("f_mwe_T1", {28'b0, mwe1}, 32'd0);
    chk("f_rsp_T1", {31'b0, if_rsp1}, 32'd0);
    chk("f_busy_T1", {31'b0, busy1}, 32'd1);
    step(); mem_rdata = 32'h13;
    #1;
    chk("f_rsp_T2", {31'b0, if_rsp1}, 32'd1);
    chk("f_data_T2", if_dat1, 32'h13);
    chk("f_drsp_T2", {31'b0, d_rsp1}, 32'd0);
    chk("f_men_T2", {31'b0, men1}, 32'd0);
    step();
    #1;
    chk("f_rsp_T3", {31'b0, if_rsp1}, 32'd0);
    chk("f_busy_T3", {31'b0, busy1}, 32'd0);

    // Store, latency 1
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h106;
    d_req_wstrb = 4'b1100; d_req_wdata = 32'hAABBCCDD;
    #1 chk("s_ready_T", {31'b0, d_rdy1}, 32'd1);
    step(); idle_inputs();
    #1;
    chk("s_maddr_T1", maddr1, 32'h104);
    chk("s_mwe_T1", {28'b0, mwe1}, 32'hC);
    chk("s_mwd_T1", mwd1, 32'hAABBCCDD);
    chk("s_men_T1", {31'b0, men1}, 32'd1);
    step();
    #1;
    chk("s_drsp_T2", {31'b0, d_rsp1}, 32'd1);
    chk("s_ifrsp_T2", {31'b0, if_rsp1}, 32'd0);
    chk("s_gid_T2", {31'b0, gid1}, 32'd1);
    step();

    // Store with empty strobe: access still issued, no bytes written, acked
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h200; d_req_wstrb = 4'b0000;
    step(); idle_inputs();
    #1;
    chk("z_men_T1", {31'b0, men1}, 32'd1);
    chk("z_mwe_T1", {28'b0, mwe1}, 32'd0);
    step();
    #1 chk("z_drsp_T2", {31'b0, d_rsp1}, 32'd1);
    step();

    // Both requesters valid every cycle for 9 cycles -> 3 accepts
    if_req_valid = 1'b1; if_req_addr = 32'h40;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h80;
    nacc = 0; last_w = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) step();
      #1;
      if (d_rdy1 || if_rdy1) begin
        chk("arb_onehot", {30'b0, d_rdy1, if_rdy1} == 2'b11 ? 32'd1 : 32'd0, 32'd0);
`ifdef MEM_ARB_RR_EN
        exp_w = (nacc % 2 == 0);
`else
        exp_w = 1'b1;
`endif
        chk($sformatf("arb_win%0d", nacc), {31'b0, d_rdy1}, {31'b0, exp_w});
        last_w = exp_w;
        nacc++;
      end else if (c > 0) begin
        chk($sformatf("arb_gid_c%0d", c), {31'b0, gid1}, {31'b0, last_w});
      end
    end
    chk("arb_naccept", nacc, 32'd3);
    step(); idle_inputs();
    step(); step(); step();

    // Latency 3 load on dut3, fetch queued behind it
    do_reset();
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h20;
    #1 chk("l3_ready_T", {31'b0, d_rdy3}, 32'd1);
    step(); idle_inputs();
    #1;
    chk("l3_men_T1", {31'b0, men3}, 32'd1);
    chk("l3_busy_T1", {31'b0, busy3}, 32'd1);
    chk("l3_maddr_T1", maddr3, 32'h20);
    step();
    #1;
    chk("l3_men_T2", {31'b0, men3}, 32'd0);
    chk("l3_busy_T2", {31'b0, busy3}, 32'd1);
    chk("l3_rsp_T2", {31'b0, d_rsp3}, 32'd0);
    step();
    if_req_valid = 1'b1; if_req_addr = 32'h30;
    #1;
    chk("l3_ifrdy_T3", {31'b0, if_rdy3}, 32'd0);
    chk("l3_rsp_T3", {31'b0, d_rsp3}, 32'd0);
    step(); mem_rdata = 32'h5555AAAA;
    #1;
    chk("l3_rsp_T4", {31'b0, d_rsp3}, 32'd1);
    chk("l3_data_T4", d_dat3, 32'h5555AAAA);
    chk("l3_ifrdy_T4", {31'b0, if_rdy3}, 32'd0);
    chk("l3_busy_T4", {31'b0, busy3}, 32'd1);
    step();
    #1;
    chk("l3_busy_T5", {31'b0, busy3}, 32'd0);
    chk("l3_ifrdy_T5", {31'b0, if_rdy3}, 32'd1);
    step(); idle_inputs();
    #1;
    chk("l3_fmen_T6", {31'b0, men3}, 32'd1);
    chk("l3_fmaddr_T6", maddr3, 32'h30);
    chk("l3_fgid_T6", {31'b0, gid3}, 32'd0);
    step(); step(); step(); step();

    // Reset one cycle into a load on dut1 aborts it
    do_reset();
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h44;
    step(); idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("ra_men", {31'b0, men1}, 32'd0);
    chk("ra_busy", {31'b0, busy1}, 32'd0);
    chk("ra_maddr", maddr1, 32'd0);
    chk("ra_gid", {31'b0, gid1}, 32'd0);
    seen_rsp = d_rsp1;
    for (int c = 0; c < 5; c++) begin
      step();
      #1 seen_rsp = seen_rsp | d_rsp1;
    end
    chk("ra_no_rsp", {31'b0, seen_rsp}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
